// File: rtl/directory_controller_if.sv
// Cache-side request/fill and directory-side invalidate/fetch signals for both caches.
interface directory_controller_if;
  logic       reqValidC0, reqValidC1;
  logic [7:0] reqAddressC0, reqAddressC1;
  logic       reqOperationC0, reqOperationC1;
  logic [7:0] reqDataC0, reqDataC1;
  logic       reqWriteBackC0, reqWriteBackC1;
  logic       reqReadyC0, reqReadyC1;
  logic [7:0] fetchDataC0, fetchDataC1;
  logic       fetchPresentC0, fetchPresentC1;
  logic       invValidC0, invValidC1;
  logic [7:0] invAddressC0, invAddressC1;
  logic       invFetchC0, invFetchC1;
  logic       invAckC0, invAckC1;
  logic [7:0] invDataC0, invDataC1;

  modport master (
    output reqValidC0, reqValidC1, reqAddressC0, reqAddressC1,
           reqOperationC0, reqOperationC1, reqDataC0, reqDataC1,
           reqWriteBackC0, reqWriteBackC1, invAckC0, invAckC1,
           invDataC0, invDataC1,
    input  reqReadyC0, reqReadyC1, fetchDataC0, fetchDataC1,
           fetchPresentC0, fetchPresentC1, invValidC0, invValidC1,
           invAddressC0, invAddressC1, invFetchC0, invFetchC1
  );

  modport slave (
    input  reqValidC0, reqValidC1, reqAddressC0, reqAddressC1,
           reqOperationC0, reqOperationC1, reqDataC0, reqDataC1,
           reqWriteBackC0, reqWriteBackC1, invAckC0, invAckC1,
           invDataC0, invDataC1,
    output reqReadyC0, reqReadyC1, fetchDataC0, fetchDataC1,
           fetchPresentC0, fetchPresentC1, invValidC0, invValidC1,
           invAddressC0, invAddressC1, invFetchC0, invFetchC1
  );
endinterface

// File: rtl/directory_controller.sv
// Two-cache directory coherence controller: 256-byte memory plus per-block
// directory (state, sharer mask), serving one request at a time.
module directory_controller (
  input  logic                 clk,
  input  logic                 reset,
  directory_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, INVAL, WAIT_ACK, RESPOND} state_t;
  typedef enum logic [1:0] {UNCACHED = 2'b00, SHARED = 2'b01, EXCLUSIVE = 2'b10} dirState_t;

  state_t     state;
  logic       rrPtr;
  dirState_t  dirState   [256];
  logic [1:0] dirSharers [256];
  logic [7:0] mem        [256];

  logic       lCache, lOp, lWb, lFetch;
  logic [7:0] lAddr, lData;

  logic [1:0] reqReady, fetchPresent, invValid, invFetch;
  logic [7:0] fetchData [2];
  logic [7:0] invAddress [2];

  logic [1:0] reqValid, reqOperation, reqWriteBack, invAck;
  logic [7:0] reqAddress [2];
  logic [7:0] reqData [2];
  logic [7:0] invData [2];

  assign reqValid      = {bus.reqValidC1, bus.reqValidC0};
  assign reqOperation  = {bus.reqOperationC1, bus.reqOperationC0};
  assign reqWriteBack  = {bus.reqWriteBackC1, bus.reqWriteBackC0};
  assign invAck        = {bus.invAckC1, bus.invAckC0};
  assign reqAddress[0] = bus.reqAddressC0;
  assign reqAddress[1] = bus.reqAddressC1;
  assign reqData[0]    = bus.reqDataC0;
  assign reqData[1]    = bus.reqDataC1;
  assign invData[0]    = bus.invDataC0;
  assign invData[1]    = bus.invDataC1;

  assign bus.reqReadyC0     = reqReady[0];
  assign bus.reqReadyC1     = reqReady[1];
  assign bus.fetchPresentC0 = fetchPresent[0];
  assign bus.fetchPresentC1 = fetchPresent[1];
  assign bus.fetchDataC0    = fetchData[0];
  assign bus.fetchDataC1    = fetchData[1];
  assign bus.invValidC0     = invValid[0];
  assign bus.invValidC1     = invValid[1];
  assign bus.invFetchC0     = invFetch[0];
  assign bus.invFetchC1     = invFetch[1];
  assign bus.invAddressC0   = invAddress[0];
  assign bus.invAddressC1   = invAddress[1];

  logic       grantCache, otherCache;
  logic [1:0] meMask, otherMask;
  dirState_t  curState;
  logic [1:0] curSharers;

  assign grantCache = (&reqValid) ? rrPtr : reqValid[1];
  assign otherCache = ~lCache;
  assign meMask     = lCache ? 2'b10 : 2'b01;
  assign otherMask  = ~meMask;
  assign curState   = dirState[lAddr];
  assign curSharers = dirSharers[lAddr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rrPtr        <= 1'b0;
      lCache       <= 1'b0;
      lOp          <= 1'b0;
      lWb          <= 1'b0;
      lFetch       <= 1'b0;
      lAddr        <= '0;
      lData        <= '0;
      reqReady     <= '0;
      fetchPresent <= '0;
      invValid     <= '0;
      invFetch     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fetchData[i]  <= '0;
        invAddress[i] <= '0;
      end
      for (int unsigned i = 0; i < 256; i++) begin
        dirState[i]   <= UNCACHED;
        dirSharers[i] <= '0;
        mem[i]        <= '0;
      end
    end else begin
      reqReady     <= '0;
      fetchPresent <= '0;
      case (state)
        IDLE: begin
          if (|reqValid) begin
            lCache             <= grantCache;
            lAddr              <= reqAddress[grantCache];
            lOp                <= reqOperation[grantCache];
            lData              <= reqData[grantCache];
            lWb                <= reqWriteBack[grantCache];
            reqReady[grantCache] <= 1'b1;
            rrPtr              <= ~rrPtr;
            state              <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lWb) begin
            if (curState == EXCLUSIVE && curSharers == meMask) begin
              mem[lAddr]        <= lData;
              dirState[lAddr]   <= UNCACHED;
              dirSharers[lAddr] <= '0;
            end
            state <= IDLE;
          end else if (!lOp) begin
            if (curState == EXCLUSIVE && curSharers != meMask) begin
              lFetch <= 1'b1;
              state  <= INVAL;
            end else begin
              if (curState != EXCLUSIVE) begin
                dirState[lAddr]   <= SHARED;
                dirSharers[lAddr] <= curSharers | meMask;
              end
              state <= RESPOND;
            end
          end else begin
            if ((curSharers & otherMask) == '0) begin
              state <= RESPOND;
            end else begin
              lFetch <= (curState == EXCLUSIVE);
              state  <= INVAL;
            end
          end
        end
        INVAL: begin
          invValid[otherCache]   <= 1'b1;
          invAddress[otherCache] <= lAddr;
          invFetch[otherCache]   <= lFetch;
          state                  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // Ack folds in the respond step so the fill lands the cycle after the ack.
          if (invAck[otherCache]) begin
            invValid[otherCache] <= 1'b0;
            if (lFetch) mem[lAddr] <= invData[otherCache];
            fetchData[lCache]    <= lFetch ? invData[otherCache] : mem[lAddr];
            fetchPresent[lCache] <= 1'b1;
            if (lOp) begin
              dirState[lAddr]   <= EXCLUSIVE;
              dirSharers[lAddr] <= meMask;
            end else begin
              dirState[lAddr]   <= SHARED;
              dirSharers[lAddr] <= 2'b11;
            end
            lFetch <= 1'b0;
            state  <= IDLE;
          end
        end
        RESPOND: begin
          fetchData[lCache]    <= mem[lAddr];
          fetchPresent[lCache] <= 1'b1;
          if (lOp) begin
            dirState[lAddr]   <= EXCLUSIVE;
            dirSharers[lAddr] <= meMask;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_directory_controller.sv
// Directed checks of the directory controller: a transaction table plus
// round-robin, stray-ack and reset-abort sequences.
module tb_directory_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  directory_controller_if bus ();
  directory_controller dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         c;
    logic [7:0] addr;
    bit         op;
    bit         wb;
    logic [7:0] data;
    bit         inv;
    bit         invFetch;
    logic [7:0] ackData;
    logic [7:0] expData;
    logic [1:0] expState;
    logic [1:0] expSh;
    logic [7:0] expMem;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setReq(input bit c, input bit v, input logic [7:0] a, input bit op,
                        input bit wb, input logic [7:0] d);
    if (!c) begin
      bus.reqValidC0 = v; bus.reqAddressC0 = a; bus.reqOperationC0 = op;
      bus.reqWriteBackC0 = wb; bus.reqDataC0 = d;
    end else begin
      bus.reqValidC1 = v; bus.reqAddressC1 = a; bus.reqOperationC1 = op;
      bus.reqWriteBackC1 = wb; bus.reqDataC1 = d;
    end
  endtask

  task automatic setAck(input bit m, input bit a, input logic [7:0] d);
    if (!m) begin bus.invAckC0 = a; bus.invDataC0 = d; end
    else    begin bus.invAckC1 = a; bus.invDataC1 = d; end
  endtask

  function automatic logic getReady(input bit c);
    return c ? bus.reqReadyC1 : bus.reqReadyC0;
  endfunction
  function automatic logic getPresent(input bit c);
    return c ? bus.fetchPresentC1 : bus.fetchPresentC0;
  endfunction
  function automatic logic [7:0] getData(input bit c);
    return c ? bus.fetchDataC1 : bus.fetchDataC0;
  endfunction
  function automatic logic getInvValid(input bit m);
    return m ? bus.invValidC1 : bus.invValidC0;
  endfunction
  function automatic logic [7:0] getInvAddr(input bit m);
    return m ? bus.invAddressC1 : bus.invAddressC0;
  endfunction
  function automatic logic getInvFetch(input bit m);
    return m ? bus.invFetchC1 : bus.invFetchC0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input bit c, input string name);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (getReady(c)) got = 1;
    end
    check({name, " ready"}, got, 1);
  endtask

  task automatic checkEntry(input string name, input logic [7:0] a, input logic [1:0] st,
                            input logic [1:0] sh, input logic [7:0] m);
    check({name, " dirState"}, dut.dirState[a], st);
    check({name, " sharers"}, dut.dirSharers[a], sh);
    check({name, " mem"}, dut.mem[a], m);
  endtask

  task automatic doTxn(input vec_t v, input string tag);
    bit m = ~v.c;
    setReq(v.c, 1, v.addr, v.op, v.wb, v.data);
    waitReady(v.c, tag);
    setReq(v.c, 0, v.addr, v.op, v.wb, v.data);
    check({tag, " other ready"}, getReady(m), 0);
    tick();
    check({tag, " present T+1"}, getPresent(v.c), 0);
    tick();
    if (!v.inv) begin
      check({tag, " present T+2"}, getPresent(v.c), !v.wb);
      if (!v.wb) check({tag, " data"}, getData(v.c), v.expData);
      check({tag, " no inv"}, getInvValid(m), 0);
    end else begin
      check({tag, " invValid"}, getInvValid(m), 1);
      check({tag, " invAddr"}, getInvAddr(m), v.addr);
      check({tag, " invFetch"}, getInvFetch(m), v.invFetch);
      tick();
      check({tag, " invValid held"}, getInvValid(m), 1);
      check({tag, " early present"}, getPresent(v.c), 0);
      setAck(m, 1, v.ackData);
      tick();
      setAck(m, 0, 8'h00);
      check({tag, " invValid drop"}, getInvValid(m), 0);
      check({tag, " present after ack"}, getPresent(v.c), 1);
      check({tag, " data"}, getData(v.c), v.expData);
    end
    checkEntry(tag, v.addr, v.expState, v.expSh, v.expMem);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int cnt;
    vec_t w;
    bus.reqValidC0 = 0; bus.reqValidC1 = 0;
    bus.reqAddressC0 = 0; bus.reqAddressC1 = 0;
    bus.reqOperationC0 = 0; bus.reqOperationC1 = 0;
    bus.reqDataC0 = 0; bus.reqDataC1 = 0;
    bus.reqWriteBackC0 = 0; bus.reqWriteBackC1 = 0;
    bus.invAckC0 = 0; bus.invAckC1 = 0;
    bus.invDataC0 = 0; bus.invDataC1 = 0;

    //            c  addr   op wb data   inv f  ack    expD   st     sh     mem
    vecs[0]  = '{0, 8'h10, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, 2'b01, 8'h00};
    vecs[1]  = '{0, 8'h20, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 2'b10, 2'b01, 8'h00};
    vecs[2]  = '{1, 8'h20, 0, 0, 8'h00, 1, 1, 8'h3C, 8'h3C, 2'b01, 2'b11, 8'h3C};
    vecs[3]  = '{0, 8'h30, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, 2'b01, 8'h00};
    vecs[4]  = '{1, 8'h30, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, 2'b11, 8'h00};
    vecs[5]  = '{1, 8'h30, 1, 0, 8'h00, 1, 0, 8'hEE, 8'h00, 2'b10, 2'b10, 8'h00};
    vecs[6]  = '{0, 8'h40, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 2'b10, 2'b01, 8'h00};
    vecs[7]  = '{0, 8'h40, 0, 1, 8'hA5, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 8'hA5};
    vecs[8]  = '{1, 8'h40, 0, 0, 8'h00, 0, 0, 8'h00, 8'hA5, 2'b01, 2'b10, 8'hA5};
    vecs[9]  = '{1, 8'h50, 0, 1, 8'h77, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00};
    vecs[10] = '{0, 8'h50, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, 2'b01, 8'h00};
    vecs[11] = '{1, 8'h20, 1, 0, 8'h00, 1, 0, 8'hEE, 8'h3C, 2'b10, 2'b10, 8'h3C};
    vecs[12] = '{1, 8'h20, 0, 0, 8'h00, 0, 0, 8'h00, 8'h3C, 2'b10, 2'b10, 8'h3C};
    vecs[13] = '{0, 8'h20, 1, 0, 8'h00, 1, 1, 8'h5A, 8'h5A, 2'b10, 2'b01, 8'h5A};

    #3;
    check("reset outputs",
          {bus.reqReadyC0, bus.reqReadyC1, bus.fetchPresentC0, bus.fetchPresentC1,
           bus.invValidC0, bus.invValidC1, bus.invFetchC0, bus.invFetchC1,
           bus.fetchDataC0, bus.fetchDataC1, bus.invAddressC0, bus.invAddressC1}, 0);
    checkEntry("reset entry", 8'h10, 2'b00, 2'b00, 8'h00);
    tick();
    reset = 0;

    for (int i = 0; i < 14; i++) doTxn(vecs[i], $sformatf("vec%0d", i));

    // stray acknowledges while no invalidate is outstanding
    setAck(0, 1, 8'h99);
    setAck(1, 1, 8'h99);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.fetchPresentC0 || bus.fetchPresentC1 || bus.invValidC0 || bus.invValidC1) bad = 1;
    end
    setAck(0, 0, 8'h00);
    setAck(1, 0, 8'h00);
    check("stray ack ignored", bad, 0);
    checkEntry("stray ack entry", 8'h20, 2'b10, 2'b01, 8'h5A);

    // round robin from reset
    reset = 1;
    setReq(0, 1, 8'h60, 0, 0, 8'h00);
    setReq(1, 1, 8'h61, 0, 0, 8'h00);
    tick();
    reset = 0;
    tick();
    check("rr first C0", bus.reqReadyC0, 1);
    check("rr first not C1", bus.reqReadyC1, 0);
    setReq(0, 0, 8'h60, 0, 0, 8'h00);
    waitReady(1, "rr second C1");
    setReq(1, 0, 8'h61, 0, 0, 8'h00);
    tick();
    tick();
    check("rr C1 present", bus.fetchPresentC1, 1);
    setReq(0, 1, 8'h62, 0, 0, 8'h00);
    setReq(1, 1, 8'h63, 0, 0, 8'h00);
    bad = 1;
    for (int i = 0; i < 20 && bad; i++) begin
      tick();
      if (bus.reqReadyC0 || bus.reqReadyC1) bad = 0;
    end
    check("rr third C0", bus.reqReadyC0, 1);
    check("rr third not C1", bus.reqReadyC1, 0);
    setReq(0, 0, 8'h62, 0, 0, 8'h00);
    waitReady(1, "rr fourth C1");
    setReq(1, 0, 8'h63, 0, 0, 8'h00);
    tick();
    tick();

    // reset while an invalidate is outstanding
    w = '{0, 8'h70, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 2'b10, 2'b01, 8'h00};
    doTxn(w, "abort setup");
    setReq(1, 1, 8'h70, 0, 0, 8'h00);
    waitReady(1, "abort req");
    setReq(1, 0, 8'h70, 0, 0, 8'h00);
    tick();
    tick();
    check("abort invValid before", bus.invValidC0, 1);
    #2 reset = 1;
    #1;
    check("abort invValid async", bus.invValidC0, 0);
    check("abort present async", {bus.fetchPresentC0, bus.fetchPresentC1}, 0);
    setAck(0, 1, 8'h11);
    tick();
    reset = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.fetchPresentC0 || bus.fetchPresentC1 || bus.invValidC0) bad = 1;
    end
    setAck(0, 0, 8'h00);
    check("abort no response", bad, 0);
    cnt = 0;
    for (int a = 0; a < 256; a++)
      if (dut.dirState[a] != 2'b00 || dut.dirSharers[a] != 2'b00 || dut.mem[a] != 8'h00) cnt++;
    check("abort entries cleared", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/directory_controller.md
DIRECTORY_CONTROLLER -- requirements
Module: directory_controller

Interface
REQ-001 Parameters: none; 256-entry address space (8-bit address), 2 caches (C0, C1).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqValidCn (n=0,1)  input  1  cache n presents a request.
REQ-005 reqAddressCn  input  8  request block address.
REQ-006 reqOperationCn  input  1  0 = read miss, 1 = write miss.
REQ-007 reqDataCn  input  8  write-back data.
REQ-008 reqWriteBackCn  input  1  1 = request is a dirty write-back (overrides reqOperationCn).
REQ-009 reqReadyCn  output  1  one-cycle pulse; request accepted this cycle.
REQ-010 fetchDataCn  output  8  fill data; valid while fetchPresentCn = 1.
REQ-011 fetchPresentCn  output  1  one-cycle pulse; fill delivered.
REQ-012 invValidCn  output  1  invalidate/fetch command to cache n, held until acknowledged.
REQ-013 invAddressCn  output  8  address of invalidate/fetch.
REQ-014 invFetchCn  output  1  1 = return data, then invalidate; 0 = invalidate only.
REQ-015 invAckCn  input  1  cache n completes the command; sampled only while invValidCn = 1.
REQ-016 invDataCn  input  8  owner data; valid with invAckCn when invFetchCn = 1.

Function
REQ-017 Per address: memory byte plus directory entry {state: UNCACHED=00, SHARED=01, EXCLUSIVE=10; sharers[1:0], bit n = cache n}; in EXCLUSIVE, the single set sharer bit is the owner.
REQ-018 FSM states: IDLE, LOOKUP, INVAL, WAIT_ACK, RESPOND. One request in service at a time.
REQ-019 IDLE: if exactly one reqValidCn, accept it; if both, grant the round-robin pointer's cache (C0 after reset); pointer toggles after every grant. The grant cycle T pulses reqReadyCn and latches address, operation, data and write-back; go to LOOKUP.
REQ-020 Write-back in LOOKUP: if requester is the EXCLUSIVE owner, write memory = reqData, state UNCACHED, sharers 00; otherwise discard data and leave the entry unchanged. Return to IDLE, no fetchPresent.
REQ-021 Read miss: UNCACHED or SHARED -> state SHARED, set requester bit, RESPOND. EXCLUSIVE with another owner -> INVAL with invFetch=1. EXCLUSIVE owned by requester -> entry unchanged, RESPOND.
REQ-022 Write miss: UNCACHED, or SHARED/EXCLUSIVE held only by requester -> RESPOND. SHARED with another sharer -> INVAL with invFetch=0. EXCLUSIVE with another owner -> INVAL with invFetch=1.
REQ-023 INVAL: assert invValidCm, invAddressCm and invFetchCm to the other cache m at T+2; go to WAIT_ACK; hold until invAckCm is sampled high.
REQ-024 On ack, invValidCm drops the next cycle. If invFetch=1, memory = invDataCm. Read miss: state SHARED, sharers 11. Write miss: sharers cleared of m. Then go to RESPOND.
REQ-025 RESPOND: fetchPresentCn = 1 for one cycle; fetchDataCn = memory byte, reflecting any same-transaction fetch. Write miss sets state EXCLUSIVE with sharers = requester only. Return to IDLE.
REQ-026 Latency: no invalidation -> fetchPresent at T+2. With invalidation -> fetchPresent one cycle after the cycle invAck is sampled.
REQ-027 fetchDataCn holds its last value when fetchPresentCn = 0. reqValid is ignored outside IDLE. invAck arriving while invValid is low is ignored.
REQ-028 The next grant is possible in the cycle after RESPOND or write-back completion.

Reset
REQ-029 On reset: FSM to IDLE; round-robin pointer to C0; every directory entry UNCACHED with sharers 00; memory all 0x00; all outputs 0.
REQ-030 Reset mid-transaction aborts the transaction immediately: invValid and fetchPresent drop asynchronously and no pending response is issued after release.

Verification
REQ-031 After reset, C0 read miss 0x10 -> reqReadyC0 at T, fetchPresentC0 at T+2 with data 0x00; entry 0x10 SHARED, sharers 01.
REQ-032 C0 write miss 0x20, then C1 read 0x20 -> invValidC0=1, invFetchC0=1, invAddressC0=0x20; C0 acks with invData 0x3C -> fetchDataC1=0x3C; entry SHARED/11; memory 0x3C.
REQ-033 C0 and C1 read 0x30, then C1 write miss 0x30 -> invValidC0 with invFetchC0=0; after ack, fetchPresentC1; entry EXCLUSIVE/10.
REQ-034 C0 write miss 0x40, C0 write-back 0x40 data 0xA5 -> no fetchPresent, entry UNCACHED; C1 read 0x40 -> fetchDataC1=0xA5. C1 write-back 0x50 data 0x77 (not owner) -> memory 0x50 remains 0x00.
REQ-035 Both reqValid high in the first cycle after reset -> C0 granted first; C1 granted in the next IDLE; the following simultaneous pair grants C0 again.
REQ-036 Reset asserted while invValidC0 = 1 -> invValidC0 = 0 immediately; no fetchPresent after release; all entries UNCACHED.
